// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and two-entry skid buffer.
// Control is zeroed in bubbles; a saturating counter tracks downstream stalls.
module pipe_stage_skid #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  // bit0 = main valid, bit1 = skid valid; both handshake flags come straight off flops
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [CTRL_W-1:0] r_main_c;
  logic [CTRL_W-1:0] r_skid_c;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;
  logic [CNT_W-1:0]  r_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_in;
  logic w_ld_skid;
  logic w_ld_fwd;
  logic w_drain;

  assign in_ready    = ~r_state[1];
  assign out_valid   = r_state[0];
  assign out_ctrl    = r_main_c;
  assign out_data    = r_main_d;
  assign stall_count = r_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_nxt     = r_state;
    w_ld_in   = 1'b0;
    w_ld_skid = 1'b0;
    w_ld_fwd  = 1'b0;
    w_drain   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_nxt   = ONE;
          w_ld_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_in = 1'b1;
        end else if (w_in_fire) begin
          w_nxt     = FULL;
          w_ld_skid = 1'b1;
        end else if (w_out_fire) begin
          w_nxt   = EMPTY;
          w_drain = 1'b1;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_nxt    = ONE;
          w_ld_fwd = 1'b1;
        end
      end
      default: begin
        w_nxt   = EMPTY;
        w_drain = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_main_c <= '0;
      r_skid_c <= '0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (flush) begin
      r_state  <= EMPTY;
      r_main_c <= '0;
      r_skid_c <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ld_in) begin
        r_main_c <= in_ctrl;
        r_main_d <= in_data;
      end
      if (w_ld_fwd) begin
        r_main_c <= r_skid_c;
        r_main_d <= r_skid_d;
      end
      if (w_ld_skid) begin
        r_skid_c <= in_ctrl;
        r_skid_d <= in_data;
      end
      if (w_drain) begin
        r_main_c <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (out_valid && !out_ready && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
